// File: rtl/hex_display_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_arbiter_pkg
// Shared definitions for the hex display arbiter: FSM state encodings and the
// geometry of the 6-digit display value bus.
// -----------------------------------------------------------------------------
package hex_display_arbiter_pkg;

    // FSM state encodings, kept as plain constants for legacy tool flows
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    // Display geometry: six 4-bit hex digits form one 24-bit value
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;
    localparam int NUM_W      = DIGIT_W * NUM_DIGITS;

endpackage

// File: rtl/hex_display_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Searches the request vector
// starting one position after the last granted index, wrapping around, and
// returns the first requester found.
//
// Ports:
//   i_req        request bit per requester
//   i_last       index of the most recently granted requester
//   o_grant_idx  winning requester index (0 when nothing is requested)
//   o_any        high when at least one request is set
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SRC_W-1:0] i_last,
    output logic [SRC_W-1:0] o_grant_idx,
    output logic             o_any
);

    int v_idx;

    // Walk offsets from farthest to nearest so the nearest pending requester
    // after i_last is the one left standing.
    always_comb begin
        o_grant_idx = {SRC_W{1'b0}};
        o_any       = 1'b0;
        v_idx       = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            v_idx = (int'(i_last) + off) % N_REQ;
            if (i_req[SRC_W'(v_idx)]) begin
                o_grant_idx = SRC_W'(v_idx);
                o_any       = 1'b1;
            end else begin
                o_any       = o_any;
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// -----------------------------------------------------------------------------
// hex_display_arbiter
// Time-shares a 6-digit hex display between N_REQ requesters. Grants are made
// round-robin and each grant is held for HOLD_CYCLES clocks; there is no
// preemption. While the granted requester keeps its request up, its value is
// followed live (one cycle of latency); when it drops, the display freezes.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_req    level-sensitive request per requester
//   i_num    packed 24-bit values, requester k at [k*24+23:k*24]
//   o_num    value driven to the 7-segment decode stage
//   o_src    current or last granted requester index
//   o_ack    one-hot, one-cycle pulse on the cycle a grant starts
//   o_busy   high while a dwell is in progress
//   o_valid  high once any grant has happened, until reset
//
// Build option:
//   HEX_ARB_TAG_EN  when defined, the top digit of o_num shows the source
//                   index and only the low 20 value bits pass through.
// -----------------------------------------------------------------------------
module hex_display_arbiter
    import hex_display_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SRC_W       = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*24-1:0] i_num,
    output logic [NUM_W-1:0]   o_num,
    output logic [SRC_W-1:0]   o_src,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_busy,
    output logic               o_valid
);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SRC_W-1:0] r_last;
    logic [SRC_W-1:0] r_src;
    logic [NUM_W-1:0] r_num;
    logic [N_REQ-1:0] r_ack;
    logic             r_busy;
    logic             r_valid;

    logic [NUM_W-1:0] w_num [N_REQ];
    logic [SRC_W-1:0] w_grant;
    logic             w_any;
    logic             w_dwell_end;
    logic             w_pick;
    logic [NUM_W-1:0] w_pick_num;
    logic [NUM_W-1:0] w_live_num;

    // Unpack the requester value bus into one word per requester
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_num[k] = i_num[k*NUM_W +: NUM_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_rr_picker (
        .i_req       (i_req),
        .i_last      (r_last),
        .o_grant_idx (w_grant),
        .o_any       (w_any)
    );

    // A pick happens whenever idle, or on the last cycle of a dwell
    assign w_dwell_end = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign w_pick      = (r_state == ST_IDLE) || w_dwell_end;

`ifdef HEX_ARB_TAG_EN
    // Top digit carries the zero-extended source index
    assign w_pick_num = {{(DIGIT_W-SRC_W){1'b0}}, w_grant, w_num[w_grant][NUM_W-DIGIT_W-1:0]};
    assign w_live_num = {{(DIGIT_W-SRC_W){1'b0}}, r_src, w_num[r_src][NUM_W-DIGIT_W-1:0]};
`else
    assign w_pick_num = w_num[w_grant];
    assign w_live_num = w_num[r_src];
`endif

    // FSM, dwell counter and all output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_last  <= SRC_W'(N_REQ - 1);
            r_src   <= {SRC_W{1'b0}};
            r_num   <= {NUM_W{1'b0}};
            r_ack   <= {N_REQ{1'b0}};
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_ack <= {N_REQ{1'b0}};
            if (w_pick && w_any) begin
                r_state <= ST_SHOW;
                r_cnt   <= {CNT_W{1'b0}};
                r_last  <= w_grant;
                r_src   <= w_grant;
                r_num   <= w_pick_num;
                r_ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_grant;
                r_busy  <= 1'b1;
                r_valid <= 1'b1;
            end else if (w_pick) begin
                // Nothing pending: fall idle, display keeps its last content
                r_state <= ST_IDLE;
                r_cnt   <= {CNT_W{1'b0}};
                r_busy  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (i_req[r_src]) begin
                    r_num <= w_live_num;
                end else begin
                    r_num <= r_num;
                end
            end
        end
    end

    assign o_num   = r_num;
    assign o_src   = r_src;
    assign o_ack   = r_ack;
    assign o_busy  = r_busy;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hex_display_arbiter
// Self-checking bench for hex_display_arbiter (N_REQ=4, HOLD_CYCLES=4).
// A cycle-level reference model tracks grants by elapsed time since the last
// grant and does the round-robin search with modular arithmetic. Directed
// scenarios are followed by a long randomized run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_display_arbiter;

    localparam int N    = 4;
    localparam int SW   = 2;
    localparam int HOLD = 4;
    localparam int CW   = 26;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*24-1:0] num = '0;
    logic [23:0]   o_num;
    logic [SW-1:0] o_src;
    logic [N-1:0]  o_ack;
    logic          o_busy;
    logic          o_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          cyc = 0;
    int          m_last = N - 1;
    int          m_src = 0;
    int          m_start = 0;
    logic [23:0] m_num = '0;
    logic [N-1:0] m_ack = '0;
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;

    hex_display_arbiter #(
        .N_REQ       (N),
        .SRC_W       (SW),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_num   (num),
        .o_num   (o_num),
        .o_src   (o_src),
        .o_ack   (o_ack),
        .o_busy  (o_busy),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [23:0] shown(input logic [23:0] v, input int s);
        logic [23:0] r;
        r = v;
`ifdef HEX_ARB_TAG_EN
        r[23:20] = 4'(s);
`endif
        return r;
    endfunction

    function automatic logic [23:0] val_of(input int k);
        return num[k*24 +: 24];
    endfunction

    // One clock edge of the reference model, using the inputs stable at the edge
    task automatic model_edge();
        int g;
        int idx;
        cyc++;
        if (!rst_n) begin
            m_last = N - 1; m_src = 0; m_num = '0; m_ack = '0;
            m_busy = 1'b0; m_valid = 1'b0; m_start = cyc;
        end else begin
            m_ack = '0;
            if (!m_busy || (cyc - m_start) == HOLD) begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (g < 0 && req[idx]) g = idx;
                end
                if (g >= 0) begin
                    m_src = g; m_last = g; m_start = cyc;
                    m_num = shown(val_of(g), g);
                    m_ack = 4'(1 << g);
                    m_busy = 1'b1; m_valid = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (req[m_src]) begin
                m_num = shown(val_of(m_src), m_src);
            end
        end
    endtask

    // Advance one clock, update the model, then compare away from the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("num",   32'(o_num),   32'(m_num));
        check_eq("src",   32'(o_src),   32'(m_src));
        check_eq("ack",   32'(o_ack),   32'(m_ack));
        check_eq("busy",  32'(o_busy),  32'(m_busy));
        check_eq("valid", 32'(o_valid), 32'(m_valid));
    endtask

    task automatic set_val(input int k, input logic [23:0] v);
        num[k*24 +: 24] = v;
    endtask

    initial begin
        // Reset with random requests
        rst_n = 1'b0;
        req = 4'($urandom);
        num = {$urandom, $urandom, $urandom};
        step();
        req = 4'($urandom);
        step();
        check_eq("rst_num",   32'(o_num),   32'h0);
        check_eq("rst_src",   32'(o_src),   32'h0);
        check_eq("rst_ack",   32'(o_ack),   32'h0);
        check_eq("rst_busy",  32'(o_busy),  32'h0);
        check_eq("rst_valid", 32'(o_valid), 32'h0);

        // Sole requester 2: immediate grant, re-granted every HOLD cycles
        rst_n = 1'b1;
        req = 4'b0100;
        set_val(2, 24'h123456);
        step();
        check_eq("sole_src", 32'(o_src), 32'd2);
        check_eq("sole_num", 32'(o_num), 32'(shown(24'h123456, 2)));
        check_eq("sole_ack", 32'(o_ack), 32'h4);
        step();
        check_eq("sole_ack_off", 32'(o_ack), 32'h0);
        for (int i = 0; i < 3; i++) step();
        check_eq("sole_regrant", 32'(o_ack), 32'h4);

        // All requesting: round-robin 3,0,1,... from the current pointer
        req = 4'b1111;
        for (int k = 0; k < N; k++) set_val(k, 24'hA00000 + 24'(k));
        for (int i = 0; i < 20; i++) step();

        // Live follow then freeze, no preemption, then requester 3 wins
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b1010; set_val(1, 24'h000111); set_val(3, 24'h333333);
        step();
        check_eq("frz_src1", 32'(o_src), 32'd1);
        set_val(1, 24'h00BEEF);
        step();
        req = 4'b1000;
        step();
        check_eq("frz_num", 32'(o_num), 32'(shown(24'h00BEEF, 1)));
        step();
        check_eq("frz_busy", 32'(o_busy), 32'd1);
        step();
        check_eq("frz_src3", 32'(o_src), 32'd3);

        // All requests drop mid-dwell: fall idle, display retained
        step();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        check_eq("idle_busy",  32'(o_busy),  32'd0);
        check_eq("idle_valid", 32'(o_valid), 32'd1);
        check_eq("idle_src",   32'(o_src),   32'd3);

        // Reset in the middle of a dwell
        req = 4'b1111;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
        check_eq("mid_rst_ack",   32'(o_ack),   32'd0);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0) req = '0;
                else req = 4'($urandom);
            end
            if ($urandom_range(0, 1) == 0)
                set_val(int'($urandom_range(0, N - 1)), 24'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
